// File: rtl/mux_arbiter_if.sv
// Request/grant bundle between requesters (master side) and the round-robin
// owner arbiter (slave side) that drives the shared 8:1 select datapath.
interface mux_arbiter_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       timeout;

    modport master (output req, done, input gnt, sel, busy, timeout);
    modport slave  (input req, done, output gnt, sel, busy, timeout);
endinterface

// File: rtl/mux_arbiter.sv
// Round-robin 8:1 ownership arbiter with registered grant/select outputs.
// Optional ARB_TIMEOUT_EN adds a hold counter that forces release after TIMEOUT_CYCLES.
module mux_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    mux_arbiter_if.slave bus
);

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    state_t     state_reg, state_next;
    logic [7:0] gnt_reg, gnt_next;
    logic [2:0] sel_reg, sel_next;
    logic [2:0] last_reg, last_next;
    logic       busy_reg, busy_next;
    logic [7:0] rot_req;
    logic [2:0] winner_off;
    logic [2:0] winner;
    logic       owner_req;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mux_arbiter: TIMEOUT_CYCLES must lie in 2..255");
    end

    // rot_req[k] is the request k+1 places after the previous owner, so the
    // lowest set bit of rot_req is the round-robin winner.
    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
        assign rot_req[gi] = bus.req[last_reg + 3'(gi + 1)];
    end

    always_comb begin
        winner_off = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (rot_req[k]) winner_off = 3'(k);
        end
    end

    assign winner    = last_reg + winner_off + 3'd1;
    assign owner_req = bus.req[sel_reg];

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] hold_cnt_reg, hold_cnt_next;
    logic       timeout_reg, timeout_next;
    logic       expire;

    assign expire = (hold_cnt_reg == HOLD_LAST);
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (|bus.req) state_next = OWN;
            end
            OWN: begin
                if (bus.done || !owner_req) state_next = IDLE;
`ifdef ARB_TIMEOUT_EN
                else if (expire) state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        gnt_next  = 8'd0;
        sel_next  = sel_reg;
        busy_next = 1'b0;
        last_next = last_reg;
        if (state_next == OWN) begin
            busy_next = 1'b1;
            if (state_reg == IDLE) begin
                gnt_next  = 8'd1 << winner;
                sel_next  = winner;
                last_next = winner;
            end else begin
                gnt_next = gnt_reg;
            end
        end
`ifdef ARB_TIMEOUT_EN
        // A release that happens with done low and the request still up can only be expiry.
        timeout_next  = (state_reg == OWN) && (state_next == IDLE) && !bus.done && owner_req;
        hold_cnt_next = (state_reg == OWN && state_next == OWN) ? hold_cnt_reg + 8'd1 : 8'd0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            gnt_reg      <= 8'd0;
            sel_reg      <= 3'd0;
            busy_reg     <= 1'b0;
            last_reg     <= 3'd7;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_reg <= 8'd0;
            timeout_reg  <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            sel_reg      <= sel_next;
            busy_reg     <= busy_next;
            last_reg     <= last_next;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_reg <= hold_cnt_next;
            timeout_reg  <= timeout_next;
`endif
        end
    end

    assign bus.gnt  = gnt_reg;
    assign bus.sel  = sel_reg;
    assign bus.busy = busy_reg;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout = timeout_reg;
`else
    assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter: stimulus queues expected grants/releases,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_mux_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mux_arbiter_if bus();

    mux_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    typedef struct { int owner; int gap; } grant_t;
    typedef struct { int to;    int hold; } rel_t;

    grant_t gq[$];
    rel_t   rq[$];

    task automatic chk(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic exp_grant(input int owner, input int gap);
        grant_t e;
        e.owner = owner;
        e.gap   = gap;
        gq.push_back(e);
    endtask

    task automatic exp_release(input int to, input int hold);
        rel_t e;
        e.to   = to;
        e.hold = hold;
        rq.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Asserts reset, checks the asynchronous clear, and releases mid-cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_gnt", int'(bus.gnt), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_sel", int'(bus.sel), 0);
        chk("rst_timeout", int'(bus.timeout), 0);
        step(2);
        #3 rst_n = 1'b1;
    endtask

    // Monitor: grant/release events, turnaround gaps, hold lengths, invariants.
    initial begin
        logic       prev_busy;
        logic [2:0] sel_prev;
        int         hold_n;
        int         idle_n;
        grant_t     g;
        rel_t       r;
        prev_busy = 1'b0;
        sel_prev  = 3'd0;
        hold_n    = 0;
        idle_n    = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_busy = 1'b0;
                sel_prev  = 3'd0;
                hold_n    = 0;
                idle_n    = 0;
            end else begin
                chk("gnt_onehot0", int'($onehot0(bus.gnt)), 1);
                chk("gnt_zero_when_idle", int'(!bus.busy && bus.gnt != 8'd0), 0);
                chk("timeout_only_at_release", int'(bus.timeout && !(prev_busy && !bus.busy)), 0);
                if (!bus.busy) chk("sel_hold_idle", int'(bus.sel), int'(sel_prev));
                if (bus.busy && !prev_busy) begin
                    chk("grant_pending", int'(gq.size() > 0), 1);
                    if (gq.size() > 0) begin
                        g = gq.pop_front();
                        chk("grant_gnt", int'(bus.gnt), 1 << g.owner);
                        chk("grant_sel", int'(bus.sel), g.owner);
                        if (g.gap >= 0) chk("grant_idle_gap", idle_n, g.gap);
                        $display("grant owner=%0d gnt=%02h sel=%0d idle_gap=%0d", g.owner, bus.gnt, bus.sel, idle_n);
                    end
                    hold_n = 0;
                end
                if (!bus.busy && prev_busy) begin
                    chk("release_pending", int'(rq.size() > 0), 1);
                    if (rq.size() > 0) begin
                        r = rq.pop_front();
                        chk("release_timeout", int'(bus.timeout), r.to);
                        if (r.hold >= 0) chk("release_hold_cycles", hold_n, r.hold);
                        $display("release hold=%0d timeout=%0d", hold_n, bus.timeout);
                    end
                    idle_n = 0;
                end
                if (bus.busy) hold_n++;
                else idle_n++;
                sel_prev  = bus.sel;
                prev_busy = bus.busy;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req  = 8'h00;
        bus.done = 1'b0;
        rst_n    = 1'b1;
        #2;

        // Single requester 0, granted on the first edge after reset, released by done.
        bus.req = 8'h01;
        exp_grant(0, -1);
        do_reset();
        step(1);
        bus.done = 1'b1;
        exp_release(0, 1);
        step(1);
        bus.done = 1'b0;
        bus.req  = 8'h00;
        step(2);

        // All requesting: rotation 0..7,0 with one idle cycle between grants.
        bus.req = 8'hFF;
        exp_grant(0, -1);
        do_reset();
        step(1);
        for (int i = 1; i <= 8; i++) begin
            bus.done = 1'b1;
            exp_release(0, 1);
            step(1);
            bus.done = 1'b0;
            exp_grant(i % 8, 1);
            step(1);
        end
        bus.done = 1'b1;
        exp_release(0, 1);
        step(1);
        bus.done = 1'b0;
        bus.req  = 8'h00;
        step(2);

        // Owner 3 is not preempted by 7; then 7, then back to 3.
        bus.req = 8'h08;
        exp_grant(3, -1);
        do_reset();
        step(1);
        bus.req = 8'h88;
        step(3);
        bus.done = 1'b1;
        exp_release(0, 4);
        step(1);
        bus.done = 1'b0;
        exp_grant(7, 1);
        step(1);
        bus.done = 1'b1;
        exp_release(0, 1);
        step(1);
        bus.done = 1'b0;
        exp_grant(3, 1);
        step(1);
        bus.done = 1'b1;
        bus.req  = 8'h00;
        exp_release(0, 1);
        step(1);
        bus.done = 1'b0;
        step(2);

        // done and owner request drop together: one release, one idle cycle, no timeout.
        bus.req = 8'h20;
        exp_grant(5, -1);
        step(1);
        bus.done = 1'b1;
        bus.req  = 8'h02;
        exp_release(0, 1);
        exp_grant(1, 1);
        step(2);
        bus.done = 1'b1;
        bus.req  = 8'h00;
        exp_release(0, 1);
        step(1);
        bus.done = 1'b0;
        step(2);

        // done in IDLE has no effect on arbitration.
        bus.done = 1'b1;
        bus.req  = 8'h10;
        exp_grant(4, -1);
        step(1);
        bus.done = 1'b0;
        step(2);
        bus.done = 1'b1;
        exp_release(0, 3);
        step(1);
        bus.done = 1'b0;
        bus.req  = 8'h00;
        step(2);

`ifdef ARB_TIMEOUT_EN
        // Forced release after TIMEOUT_CYCLES OWN cycles, then done coinciding with expiry.
        bus.req = 8'h20;
        exp_grant(5, -1);
        exp_release(1, 16);
        step(17);
        bus.req = 8'h00;
        step(2);
        bus.req = 8'h20;
        exp_grant(5, -1);
        step(16);
        bus.done = 1'b1;
        exp_release(0, 16);
        step(1);
        bus.done = 1'b0;
        bus.req  = 8'h00;
        step(2);
`else
        // Without the timeout option a grant is held indefinitely.
        bus.req = 8'h20;
        exp_grant(5, -1);
        step(101);
        chk("held_after_100", int'(bus.busy), 1);
        bus.done = 1'b1;
        exp_release(0, 101);
        step(1);
        bus.done = 1'b0;
        bus.req  = 8'h00;
        step(2);
`endif

        // Asynchronous reset while owner 6 holds, then regrant of 6.
        bus.req = 8'h40;
        exp_grant(6, -1);
        step(3);
        #2;
        chk("pre_reset_busy", int'(bus.busy), 1);
        exp_grant(6, -1);
        do_reset();
        step(1);
        bus.done = 1'b1;
        exp_release(0, 1);
        step(1);
        bus.done = 1'b0;
        bus.req  = 8'h00;
        step(3);

        for (int i = 0; i < 50 && (gq.size() > 0 || rq.size() > 0); i++) @(posedge clk);
        chk("grant_queue_drained", gq.size(), 0);
        chk("release_queue_drained", rq.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
